// File: rtl/prog_loader.sv
// Program-memory loader: frames a 16-bit valid/ready stream (count, halfword pairs, checksum)
// into 32-bit instruction writes. Optional idle timeout is enabled by LOADER_TIMEOUT_EN.
module prog_loader #(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned AW      = 4,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic          clk,
  input  logic          sys_rst,
  input  logic          start,
  input  logic [15:0]   din,
  input  logic          din_valid,
  output logic          din_ready,
  output logic          imem_we,
  output logic [AW-1:0] imem_addr,
  output logic [31:0]   imem_wdata,
  output logic          cpu_hold,
  output logic          load_done,
  output logic          load_err,
  output logic [1:0]    err_code
);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_HI, S_LO, S_WRITE, S_CSUM, S_DONE, S_ERR
  } state_t;

  localparam logic [AW:0] CntOne = 1;

  state_t      state, nxt;
  logic [1:0]  err_cause;
  logic [AW:0] n_q, cnt;
  logic [15:0] sum, hi_q;
  logic        xfer, waiting, bad_count, last_word, timed_out;

  assign xfer      = din_valid & din_ready;
  assign waiting   = (state == S_HDR) || (state == S_HI) || (state == S_LO) || (state == S_CSUM);
  assign bad_count = (din == '0) || (din > 16'(DEPTH));
  assign last_word = (cnt + CntOne) == n_q;

`ifdef LOADER_TIMEOUT_EN
  localparam int unsigned IW = $clog2(TIMEOUT + 1);
  logic [IW-1:0] idle_cnt;

  assign timed_out = waiting && !xfer && (idle_cnt == IW'(TIMEOUT - 1));

  // Restarts on every transfer and whenever the state changes, so each wait is timed afresh.
  always_ff @(posedge clk) begin
    if (sys_rst || xfer || !waiting || (nxt != state)) idle_cnt <= '0;
    else                                               idle_cnt <= idle_cnt + 1'b1;
  end
`else
  logic unused_timeout;
  assign timed_out      = 1'b0;
  assign unused_timeout = ^TIMEOUT;
`endif

  always_comb begin
    nxt       = state;
    err_cause = 2'd0;
    case (state)
      S_IDLE, S_DONE, S_ERR: if (start) nxt = S_HDR;
      S_HDR: if (xfer) begin
        if (bad_count) begin
          nxt       = S_ERR;
          err_cause = 2'd1;
        end else begin
          nxt = S_HI;
        end
      end
      S_HI:    if (xfer) nxt = S_LO;
      S_LO:    if (xfer) nxt = S_WRITE;
      S_WRITE: nxt = last_word ? S_CSUM : S_HI;
      S_CSUM: if (xfer) begin
        if (din == sum) begin
          nxt = S_DONE;
        end else begin
          nxt       = S_ERR;
          err_cause = 2'd2;
        end
      end
      default: nxt = S_IDLE;
    endcase
    if (timed_out) begin
      nxt       = S_ERR;
      err_cause = 2'd3;
    end
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (sys_rst) begin
      state      <= S_IDLE;
      din_ready  <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      cpu_hold   <= 1'b0;
      load_done  <= 1'b0;
      load_err   <= 1'b0;
      err_code   <= '0;
      sum        <= '0;
      hi_q       <= '0;
      n_q        <= '0;
      cnt        <= '0;
    end else begin
      state     <= nxt;
      din_ready <= (nxt == S_HDR) || (nxt == S_HI) || (nxt == S_LO) || (nxt == S_CSUM);
      imem_we   <= (nxt == S_WRITE);
      cpu_hold  <= !((nxt == S_IDLE) || (nxt == S_DONE));
      load_done <= (nxt == S_DONE);
      load_err  <= (nxt == S_ERR);
      if (nxt != S_ERR)       err_code <= '0;
      else if (state != S_ERR) err_code <= err_cause;

      case (state)
        S_HDR: if (xfer) begin
          sum <= din;
          n_q <= din[AW:0];
          cnt <= '0;
        end
        S_HI: if (xfer) begin
          hi_q <= din;
          sum  <= sum + din;
        end
        S_LO: if (xfer) begin
          sum        <= sum + din;
          imem_addr  <= cnt[AW-1:0];
          imem_wdata <= {hi_q, din};
        end
        S_WRITE: cnt <= cnt + CntOne;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: expected writes are queued as words are driven and
// matched against the program-memory write port.
module tb_prog_loader;

  typedef struct {
    logic [3:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        sys_rst, start, din_valid;
  logic [15:0] din;
  logic        din_ready, imem_we, cpu_hold, load_done, load_err;
  logic [3:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic [1:0]  err_code;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned n_writes = 0;
  wr_t         exp_q[$];
  logic [31:0] words[16];

  prog_loader #(.DEPTH(16), .AW(4), .TIMEOUT(8)) dut (
    .clk(clk), .sys_rst(sys_rst), .start(start), .din(din), .din_valid(din_valid),
    .din_ready(din_ready), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_hold(cpu_hold), .load_done(load_done), .load_err(load_err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (imem_we) begin
      wr_t e;
      n_writes++;
      check("wr_ready_low", 32'(din_ready), 32'd0);
      if (exp_q.size() == 0) begin
        check("wr_pending", 32'(exp_q.size()), 32'd1);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", 32'(imem_addr), 32'(e.addr));
        check("wr_data", imem_wdata, e.data);
      end
    end
  end

  // All tasks begin and end on a falling edge.
  task automatic send(input logic [15:0] w, input int gap);
    repeat (gap) begin
      din_valid = 1'b0;
      @(negedge clk);
    end
    din       = w;
    din_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (din_ready) begin
        @(negedge clk);
        din_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    check("ready_wait", 32'(din_ready), 32'd1);
    din_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Checksum is the 16-bit wrapping sum of the header and every halfword.
  task automatic run_frame(input int n, input int gap, input bit bad_sum);
    logic [15:0] s;
    s = 16'(n);
    send(16'(n), 0);
    for (int i = 0; i < n; i++) begin
      send(words[i][31:16], gap);
      s += words[i][31:16];
      exp_q.push_back('{addr: 4'(i), data: words[i]});
      send(words[i][15:0], gap);
      s += words[i][15:0];
    end
    send(bad_sum ? s + 16'd1 : s, gap);
  endtask

  task automatic wait_end();
    for (int i = 0; i < 20; i++) begin
      if (load_done || load_err) break;
      @(negedge clk);
    end
    check("end_seen", 32'(load_done | load_err), 32'd1);
  endtask

  task automatic check_status(input string tag, input logic done, input logic err,
                              input logic hold, input logic [1:0] code);
    check({tag, "_done"}, 32'(load_done), 32'(done));
    check({tag, "_err"},  32'(load_err),  32'(err));
    check({tag, "_hold"}, 32'(cpu_hold),  32'(hold));
    check({tag, "_code"}, 32'(err_code),  32'(code));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, 32'(din_ready), 32'd0);
    check({tag, "_we"},    32'(imem_we),   32'd0);
    check({tag, "_addr"},  32'(imem_addr), 32'd0);
    check({tag, "_wdata"}, imem_wdata,     32'd0);
    check_status(tag, 1'b0, 1'b0, 1'b0, 2'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned w0;
    sys_rst = 1'b1; start = 1'b0; din = '0; din_valid = 1'b0;
    repeat (3) @(negedge clk);
    sys_rst = 1'b0;
    check_all_zero("reset");

    // Good two-word load.
    words[0] = 32'h0840_0005;
    words[1] = 32'h1000_0003;
    pulse_start();
    check("start_hold", 32'(cpu_hold), 32'd1);
    check("start_ready", 32'(din_ready), 32'd1);
    w0 = n_writes;
    run_frame(2, 0, 1'b0);
    wait_end();
    check("good_writes", n_writes - w0, 32'd2);
    check_status("good", 1'b1, 1'b0, 1'b0, 2'd0);

    // Bad header counts: zero and DEPTH+1.
    w0 = n_writes;
    pulse_start();
    check("restart_done_clr", 32'(load_done), 32'd0);
    send(16'h0000, 0);
    wait_end();
    check_status("cnt0", 1'b0, 1'b1, 1'b1, 2'd1);
    pulse_start();
    check("restart_err_clr", 32'(load_err), 32'd0);
    check("restart_code_clr", 32'(err_code), 32'd0);
    send(16'h0011, 0);
    wait_end();
    check_status("cnt17", 1'b0, 1'b1, 1'b1, 2'd1);
    check("cnt_nowrites", n_writes - w0, 32'd0);

    // Checksum mismatch: both writes still happen.
    w0 = n_writes;
    pulse_start();
    run_frame(2, 0, 1'b1);
    wait_end();
    check("csum_writes", n_writes - w0, 32'd2);
    check_status("csum", 1'b0, 1'b1, 1'b1, 2'd2);

    // Full-depth load with a one-cycle valid gap before every word.
    for (int i = 0; i < 16; i++) words[i] = $urandom;
    w0 = n_writes;
    pulse_start();
    run_frame(16, 1, 1'b0);
    wait_end();
    check("full_writes", n_writes - w0, 32'd16);
    check_status("full", 1'b1, 1'b0, 1'b0, 2'd0);

    // Reset one cycle after the first write of a frame.
    words[0] = 32'h0840_0005;
    words[1] = 32'h1000_0003;
    pulse_start();
    send(16'd2, 0);
    send(words[0][31:16], 0);
    exp_q.push_back('{addr: 4'd0, data: words[0]});
    send(words[0][15:0], 0);
    @(negedge clk);
    sys_rst = 1'b1;
    @(negedge clk);
    sys_rst = 1'b0;
    check_all_zero("midrst");
    pulse_start();
    run_frame(2, 0, 1'b0);
    wait_end();
    check_status("after_rst", 1'b1, 1'b0, 1'b0, 2'd0);

`ifdef LOADER_TIMEOUT_EN
    // Seven idle cycles in LO are tolerated; eight are not.
    words[0] = 32'hCAFE_F00D;
    pulse_start();
    send(16'd1, 0);
    send(words[0][31:16], 0);
    exp_q.push_back('{addr: 4'd0, data: words[0]});
    send(words[0][15:0], 7);
    send(16'd1 + words[0][31:16] + words[0][15:0], 0);
    wait_end();
    check_status("stall7", 1'b1, 1'b0, 1'b0, 2'd0);
    w0 = n_writes;
    pulse_start();
    send(16'd1, 0);
    send(words[0][31:16], 0);
    repeat (8) @(negedge clk);
    check_status("stall8", 1'b0, 1'b1, 1'b1, 2'd3);
    check("stall8_ready", 32'(din_ready), 32'd0);
    check("stall8_nowrite", n_writes - w0, 32'd0);
`endif

    repeat (3) @(negedge clk);
    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
